seq_pattern_gen: RTL

//  Serial pattern transmitter: the stimulus end of the sequence-detector FSMs.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_shift_reg.sv | 55 +++++
 rtl/seq_pattern_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator/detector family: state encodings,
// state width and effective-length helper.
package seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  // A requested length of 0, or one wider than the pattern, selects the full width.
  function automatic int unsigned eff_len(int unsigned len, int unsigned w);
    return ((len == 0) || (len > w)) ? w : len;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shifter: the current bit is always sh[W-1], so the serial
// output comes straight from a flop. A saved copy allows restarting a repetition.
module seq_shift_reg #(
  parameter int W  = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          reload,
  input  logic          shift,
  input  logic          clear,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  output logic          bit_out,
  output logic          last
);

  logic [W-1:0]  sh;
  logic [W-1:0]  saved;
  logic [W-1:0]  aligned;
  logic [LW-1:0] idx;
  logic [LW-1:0] len_q;

  // Left-justify pattern[len-1:0] so its top bit leaves first.
  always_comb begin
    aligned = pattern << (W - int'(len));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh    <= '0;
      saved <= '0;
      idx   <= '0;
      len_q <= '0;
    end else if (load) begin
      sh    <= aligned;
      saved <= aligned;
      len_q <= len;
      idx   <= len - LW'(1);
    end else if (reload) begin
      sh  <= saved;
      idx <= len_q - LW'(1);
    end else if (shift) begin
      sh  <= {sh[W-2:0], 1'b0};
      idx <= idx - LW'(1);
    end else if (clear) begin
      sh <= '0;
    end
  end

  assign bit_out = sh[W-1];
  assign last    = (idx == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: FSM, repetition counter and shifter.
// Define SEQ_GAP_EN to insert GAP idle cycles between repetitions.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int LW  = 4,
  parameter int RW  = 4,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len_in,
  input  logic [RW-1:0] reps_in,
  output logic          x,
  output logic          x_valid,
  output logic          busy,
  output logic          done
);

  if (((1 << LW) <= W) || (GAP < 0)) begin : g_cfg_check
    $error("seq_pattern_gen: need 2**LW > W and GAP >= 0");
  end

  seq_state_t    state, state_n;
  logic [RW-1:0] rep_cnt, rep_n;
  logic [LW-1:0] len_eff;
  logic [RW-1:0] reps_eff;
  logic          load, reload, shift, clear;
  logic          x_valid_n, busy_n, done_n;
  logic          last;

`ifdef SEQ_GAP_EN
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  logic [GW-1:0] gap_cnt, gap_n;
`endif

  assign len_eff  = LW'(eff_len(int'(len_in), W));
  assign reps_eff = (reps_in == '0) ? RW'(1) : reps_in;

  seq_shift_reg #(.W(W), .LW(LW)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .reload  (reload),
    .shift   (shift),
    .clear   (clear),
    .pattern (pattern),
    .len     (len_eff),
    .bit_out (x),
    .last    (last)
  );

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    state_n   = state;
    rep_n     = rep_cnt;
    load      = 1'b0;
    reload    = 1'b0;
    shift     = 1'b0;
    clear     = 1'b1;
    x_valid_n = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
`ifdef SEQ_GAP_EN
    gap_n     = gap_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          rep_n     = reps_eff - RW'(1);
          state_n   = S_SHIFT;
          x_valid_n = 1'b1;
          busy_n    = 1'b1;
        end
      end
      S_SHIFT: begin
        busy_n = 1'b1;
        if (!last) begin
          shift     = 1'b1;
          x_valid_n = 1'b1;
        end else if (rep_cnt != '0) begin
          rep_n = rep_cnt - RW'(1);
`ifdef SEQ_GAP_EN
          if (GAP > 0) begin
            gap_n   = GW'(GAP - 1);
            state_n = S_GAP;
          end else begin
            reload    = 1'b1;
            x_valid_n = 1'b1;
          end
`else
          reload    = 1'b1;
          x_valid_n = 1'b1;
`endif
        end else begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end
`ifdef SEQ_GAP_EN
      S_GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == '0) begin
          reload    = 1'b1;
          x_valid_n = 1'b1;
          state_n   = S_SHIFT;
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
`endif
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rep_cnt <= '0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      rep_cnt <= rep_n;
      x_valid <= x_valid_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SEQ_GAP_EN
      gap_cnt <= gap_n;
`endif
    end
  end

endmodule
